// File: rtl/perif_gpio.sv
// perif_gpio: memory-mapped GPIO controller feeding the IO function selector.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_addr[4:2]         register word address
//   i_be                write byte enables
//   i_wr_en, i_rd_en    requests, held by the master until o_ack
//   i_wr_data           write data
//   o_rd_data           read data, held until the next read
//   o_busy              always 0
//   o_ack               one-cycle transfer acknowledge
//   i_gpio_in           raw asynchronous pad input from the selector
//   o_gpio_out          output value
//   o_gpio_out_en       output enable (1 = drive)
//   o_gpio_pullup       pull-up enable
//   o_gpio_pulldown     pull-down enable (suppressed where pull-up is set)
//   o_irq               level interrupt, OR of all pending bits
//
// Register map (word offset): 0 OUT, 1 IN (RO), 2 OUT_EN, 3 PULLUP, 4 PULLDOWN,
// 5 RISE_EN, 6 FALL_EN, 7 PENDING (W1C).

module perif_gpio #(
    parameter int unsigned p_num_gpios   = 24,
    parameter int unsigned p_sync_stages = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [4:2]             i_addr,
    input  logic [3:0]             i_be,
    input  logic                   i_wr_en,
    input  logic [31:0]            i_wr_data,
    input  logic                   i_rd_en,
    output logic [31:0]            o_rd_data,
    output logic                   o_busy,
    output logic                   o_ack,
    input  logic [p_num_gpios-1:0] i_gpio_in,
    output logic [p_num_gpios-1:0] o_gpio_out,
    output logic [p_num_gpios-1:0] o_gpio_out_en,
    output logic [p_num_gpios-1:0] o_gpio_pullup,
    output logic [p_num_gpios-1:0] o_gpio_pulldown,
    output logic                   o_irq
);

    localparam logic [31:0] ValidMask =
        (p_num_gpios >= 32) ? 32'hFFFF_FFFF : ((32'd1 << p_num_gpios) - 32'd1);

    typedef enum logic [1:0] {StIdle, StAck, StWaitDrop} state_e;

    state_e state_q, state_d;

    logic [p_num_gpios-1:0] out_q,     out_d;
    logic [p_num_gpios-1:0] out_en_q,  out_en_d;
    logic [p_num_gpios-1:0] pullup_q,  pullup_d;
    logic [p_num_gpios-1:0] pulldn_q,  pulldn_d;
    logic [p_num_gpios-1:0] rise_en_q, rise_en_d;
    logic [p_num_gpios-1:0] fall_en_q, fall_en_d;
    logic [p_num_gpios-1:0] pending_q, pending_d;
    logic [31:0]            rd_data_q, rd_data_d;
    logic                   irq_q;

    logic [p_sync_stages-1:0][p_num_gpios-1:0] sync_q;
    logic [p_num_gpios-1:0] sync_in;
    logic [p_num_gpios-1:0] prev_q;
    logic [p_num_gpios-1:0] edge_set;

    logic                   req;
    logic                   accept;
    logic                   wr_commit;
    logic                   rd_commit;
    logic [31:0]            be_mask;
    logic [p_num_gpios-1:0] wmask;
    logic [p_num_gpios-1:0] wdata;
    logic [p_num_gpios-1:0] w1c;
    logic                   unused_wr_bits;

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    assign req       = i_wr_en | i_rd_en;
    assign accept    = (state_q == StIdle) && req;
    assign wr_commit = accept && i_wr_en;
    // A simultaneous write takes priority and leaves the read data untouched.
    assign rd_commit = accept && i_rd_en && !i_wr_en;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (req) state_d = StAck;
            StAck:      state_d = StWaitDrop;
            // Wait for the master to drop its request so a held request acks only once.
            StWaitDrop: if (!req) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        o_ack = (state_q == StAck);
    end

    assign o_busy = 1'b0;

    // ------------------------------------------------------------------
    // Input synchroniser and edge detection
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= i_gpio_in;
            for (int s = 1; s < int'(p_sync_stages); s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_in;
        end
    end

    assign sync_in  = sync_q[p_sync_stages-1];
    assign edge_set = (sync_in & ~prev_q & rise_en_q) | (~sync_in & prev_q & fall_en_q);

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    assign be_mask = {{8{i_be[3]}}, {8{i_be[2]}}, {8{i_be[1]}}, {8{i_be[0]}}};
    assign wmask   = be_mask[p_num_gpios-1:0];
    assign wdata   = i_wr_data[p_num_gpios-1:0];
    // Bits above the pin count have no storage behind them.
    assign unused_wr_bits = ^{be_mask & ~ValidMask, i_wr_data & ~ValidMask};

    function automatic logic [p_num_gpios-1:0] merge(
        input logic [p_num_gpios-1:0] cur,
        input logic [p_num_gpios-1:0] mask,
        input logic [p_num_gpios-1:0] data
    );
        return (cur & ~mask) | (data & mask);
    endfunction

    always_comb begin
        out_d     = out_q;
        out_en_d  = out_en_q;
        pullup_d  = pullup_q;
        pulldn_d  = pulldn_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
        if (wr_commit) begin
            unique case (i_addr)
                3'd0: out_d     = merge(out_q, wmask, wdata);
                3'd1: ;
                3'd2: out_en_d  = merge(out_en_q, wmask, wdata);
                3'd3: pullup_d  = merge(pullup_q, wmask, wdata);
                3'd4: pulldn_d  = merge(pulldn_q, wmask, wdata);
                3'd5: rise_en_d = merge(rise_en_q, wmask, wdata);
                3'd6: fall_en_d = merge(fall_en_q, wmask, wdata);
                3'd7: w1c       = wmask & wdata;
                default: ;
            endcase
        end
        // A new edge in the same cycle as a clear keeps the bit set.
        pending_d = (pending_q & ~w1c) | edge_set;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_commit) begin
            unique case (i_addr)
                3'd0: rd_data_d = 32'(out_q);
                3'd1: rd_data_d = 32'(sync_in);
                3'd2: rd_data_d = 32'(out_en_q);
                3'd3: rd_data_d = 32'(pullup_q);
                3'd4: rd_data_d = 32'(pulldn_q);
                3'd5: rd_data_d = 32'(rise_en_q);
                3'd6: rd_data_d = 32'(fall_en_q);
                3'd7: rd_data_d = 32'(pending_q);
                default: rd_data_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_q     <= '0;
            out_en_q  <= '0;
            pullup_q  <= '0;
            pulldn_q  <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pending_q <= '0;
            rd_data_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            out_en_q  <= out_en_d;
            pullup_q  <= pullup_d;
            pulldn_q  <= pulldn_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pending_q <= pending_d;
            rd_data_q <= rd_data_d;
            irq_q     <= |pending_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_rd_data       = rd_data_q;
    assign o_gpio_out      = out_q;
    assign o_gpio_out_en   = out_en_q;
    assign o_gpio_pullup   = pullup_q;
    assign o_gpio_pulldown = pulldn_q & ~pullup_q;
    assign o_irq           = irq_q;

endmodule

// File: doc/perif_gpio.md
Name: perif_gpio

Overview:
- Memory-mapped GPIO controller sitting directly upstream of the IO function selector.
- Drives the selector's per-pin GPIO function inputs: output value, output enable, pull-up and pull-down.
- Consumes the selector's raw pad input (o_gpio_in), synchronises it and exposes it to software.
- Generates a level interrupt from per-pin rising/falling-edge detection.

Parameters:
p_num_gpios, 24, number of GPIO pins handled (1..32)
p_sync_stages, 2, input synchroniser depth in flops (>=2)

Ports:
i_clk  input  1  global clock
i_rst  input  1  global reset
i_addr  input  3 [4:2]  register word address
i_be  input  4  write byte enable
i_wr_en  input  1  write request, held until o_ack
i_wr_data  input  32  write data
i_rd_en  input  1  read request, held until o_ack
o_rd_data  output  32  read data
o_busy  output  1  busy, tied 0
o_ack  output  1  transfer acknowledge
i_gpio_in  input  p_num_gpios  raw pad input from function selector (asynchronous)
o_gpio_out  output  p_num_gpios  output value to function selector
o_gpio_out_en  output  p_num_gpios  output enable, 1 = output
o_gpio_pullup  output  p_num_gpios  pull-up enable
o_gpio_pulldown  output  p_num_gpios  pull-down enable
o_irq  output  1  interrupt, level, active-high

Behaviour:
- Clocking and reset: single clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset values: all registers 0, synchroniser chain 0, o_ack=0, o_rd_data=0, o_irq=0.
- Register map (word offset, access):
  - 0 OUT, RW
  - 1 IN, RO, synchronised input
  - 2 OUT_EN, RW
  - 3 PULLUP, RW
  - 4 PULLDOWN, RW
  - 5 RISE_EN, RW
  - 6 FALL_EN, RW
  - 7 PENDING, W1C
- Bit ranges: bits >= p_num_gpios are not stored and read 0. Writes honour i_be per byte; W1C honours i_be too. Writes to IN are ignored but acknowledged.
- Pad outputs:
  - o_gpio_out = OUT, o_gpio_out_en = OUT_EN, o_gpio_pullup = PULLUP.
  - o_gpio_pulldown = PULLDOWN & ~PULLUP: pull-up wins on conflict.
  - All pad outputs are register-driven, with no combinational path from the bus.
- Handshake FSM, states IDLE, ACK, WAIT_DROP:
  - IDLE: on (i_wr_en | i_rd_en) go to ACK. The write is committed, or read data captured into o_rd_data, at the same edge.
  - ACK: o_ack=1 for exactly one cycle, then go to WAIT_DROP.
  - WAIT_DROP: stay until both requests are low, then go to IDLE. This prevents a double ack on a held request.
  - Latency: request in cycle N produces o_ack in cycle N+1.
  - i_wr_en and i_rd_en high together: the write wins; o_rd_data is unchanged.
  - o_rd_data holds its value until the next read.
- Input path:
  - i_gpio_in passes through p_sync_stages flops to give sync.
  - IN register reads sync, total latency p_sync_stages cycles.
  - Edge detection compares sync against a one-cycle-delayed copy, prev.
  - Rise on bit i: sync=1 & prev=0. Fall on bit i: sync=0 & prev=1.
- PENDING[i]:
  - Sets on (rise & RISE_EN[i]) | (fall & FALL_EN[i]).
  - Cleared by writing 1.
  - Set and W1C clear in the same cycle: set wins.
  - Clearing RISE_EN or FALL_EN does not clear PENDING.
- o_irq = |PENDING, registered one cycle after PENDING changes.
- Reset mid-transfer: FSM returns to IDLE and no ack is issued. The master must re-issue the request.

Test Plan:
- Reset, then read all 8 offsets: each returns 0x00000000 with o_ack one cycle after i_rd_en; o_busy stays 0 throughout.
- Write OUT=0xFFFFFFFF with i_be=4'b0101, read back: 0x00FF00FF masked to 24 bits gives 0x00FF00FF; o_gpio_out matches one cycle after ack.
- Pull conflict: write PULLUP=0x1 and PULLDOWN=0x3 -> o_gpio_pullup=0x000001, o_gpio_pulldown=0x000002.
- Rising edge: RISE_EN=0x10, drive i_gpio_in[4] 0->1 -> IN bit 4 reads 1 after 2 cycles; PENDING=0x10 in the next cycle; o_irq=1 one cycle later. Write PENDING=0x10 -> o_irq returns to 0.
- Same-cycle conflict: a W1C of PENDING bit 4 coincides with a new enabled edge on pin 4 -> PENDING[4] remains 1 and o_irq stays high.
- Held request: hold i_rd_en high for 5 cycles -> exactly one o_ack pulse. Assert i_rst during the ACK state -> no ack, all outputs return to 0.
